// File: rtl/fetch_sequencer.sv
// fetch_sequencer: FETCH/EXEC bus sequencer owning the single Avalon-style memory port of the MIPS CPU
// Ports: clk, reset_n (async active-low); pc, mem_req/mem_we/mem_addr/mem_byteenable/mem_wdata (datapath
// load/store request), halt_req, waitrequest in; address/read/write/byteenable/writedata (bus), state/stall
// (instruction register), pc_en, active, bus_error, instr_count out.
// Optional FETCH_SEQ_TIMEOUT_EN: faults after TIMEOUT_CYCLES consecutive waitrequest cycles on a strobe.
module fetch_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_wdata,
  input  logic        halt_req,
  input  logic        waitrequest,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        state,
  output logic        stall,
  output logic        pc_en,
  output logic        active,
  output logic        bus_error,
  output logic [31:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALT, FAULT} st_t;
  st_t cur, nxt;
  logic retire, tmo, fetch, access;
  assign retire = cur == EXEC && (!mem_req || !waitrequest);
`ifdef FETCH_SEQ_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic waiting;
  assign waiting = (read || write) && waitrequest;
  assign tmo = waiting && wait_cnt == 16'(TIMEOUT_CYCLES - 1);
  assign bus_error = cur == FAULT;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) wait_cnt <= '0;
    else wait_cnt <= waiting ? wait_cnt + 16'd1 : '0;
`else
  assign tmo = 1'b0;
  assign bus_error = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cur <= IDLE;
    else cur <= nxt;
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:  nxt = FETCH;
      FETCH: nxt = tmo ? FAULT : waitrequest ? FETCH : EXEC;
      EXEC:  nxt = tmo ? FAULT : !retire ? EXEC : halt_req ? HALT : FETCH;
      default: nxt = cur;
    endcase
  end
  always_comb begin
    fetch = cur == FETCH;
    access = cur == EXEC && mem_req;
    read = fetch || (access && !mem_we);
    write = access && mem_we;
    address = fetch ? pc : access ? mem_addr : '0;
    byteenable = fetch ? 4'hF : access ? mem_byteenable : '0;
    writedata = access ? mem_wdata : '0;
    state = cur == EXEC;
    stall = access && waitrequest;
    pc_en = retire;
    active = fetch || cur == EXEC;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) instr_count <= '0;
    else if (retire) instr_count <= instr_count + 32'd1;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
  logic clk = 0, reset_n = 0, mem_req = 0, mem_we = 0, halt_req = 0, waitrequest = 0;
  logic [31:0] pc = 32'hBFC00000, mem_addr = 0, mem_wdata = 0;
  logic [3:0] mem_byteenable = 0;
  logic [31:0] address, writedata, instr_count;
  logic [3:0] byteenable;
  logic read, write, state, stall, pc_en, active, bus_error;
  localparam int I = 0, F = 1, E = 2, H = 3, X = 4;
  typedef struct {
    logic [31:0] addr, wd, cnt;
    logic [3:0] be;
    logic rd, wr, st, stl, pe, act, err;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int errors = 0, checks = 0;
  logic [31:0] cnt_exp = 0;
  always #5 clk = ~clk;
  fetch_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_byteenable(mem_byteenable), .mem_wdata(mem_wdata),
    .halt_req(halt_req), .waitrequest(waitrequest), .address(address), .read(read),
    .write(write), .byteenable(byteenable), .writedata(writedata), .state(state),
    .stall(stall), .pc_en(pc_en), .active(active), .bus_error(bus_error),
    .instr_count(instr_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input int ph, input logic wr, input logic mr, input logic we,
                      input logic hr, input logic e_stall, input logic e_pcen);
    exp_t e;
    logic acc;
    waitrequest = wr;
    mem_req = mr;
    mem_we = we;
    halt_req = hr;
    acc = ph == E && mr;
    e.rd = ph == F || (acc && !we);
    e.wr = acc && we;
    e.addr = ph == F ? pc : acc ? mem_addr : 32'h0;
    e.be = ph == F ? 4'hF : acc ? mem_byteenable : 4'h0;
    e.wd = acc ? mem_wdata : 32'h0;
    e.st = ph == E;
    e.stl = e_stall;
    e.pe = e_pcen;
    e.act = ph == F || ph == E;
    e.err = ph == X;
    e.cnt = cnt_exp;
    q.push_back(e);
    if (e_pcen) cnt_exp++;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      m = q.pop_front();
      chk("read", 32'(read), 32'(m.rd));
      chk("write", 32'(write), 32'(m.wr));
      chk("address", address, m.addr);
      chk("byteenable", 32'(byteenable), 32'(m.be));
      chk("writedata", writedata, m.wd);
      chk("state", 32'(state), 32'(m.st));
      chk("stall", 32'(stall), 32'(m.stl));
      chk("pc_en", 32'(pc_en), 32'(m.pe));
      chk("active", 32'(active), 32'(m.act));
      chk("bus_error", 32'(bus_error), 32'(m.err));
      chk("instr_count", instr_count, m.cnt);
    end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst read", 32'(read), 0);
    chk("rst write", 32'(write), 0);
    chk("rst state", 32'(state), 0);
    chk("rst stall", 32'(stall), 0);
    chk("rst pc_en", 32'(pc_en), 0);
    chk("rst active", 32'(active), 0);
    chk("rst bus_error", 32'(bus_error), 0);
    chk("rst address", address, 0);
    chk("rst byteenable", 32'(byteenable), 0);
    chk("rst writedata", writedata, 0);
    chk("rst instr_count", instr_count, 0);
    reset_n = 1;
    step(I, 0, 0, 0, 0, 0, 0);
    repeat (4) begin
      step(F, 0, 0, 0, 0, 0, 0);
      step(E, 0, 0, 0, 0, 0, 1);
    end
    step(F, 0, 0, 0, 0, 0, 0);
    step(E, 0, 0, 0, 0, 0, 1);
    repeat (3) step(F, 1, 0, 0, 0, 0, 0);
    step(F, 0, 0, 0, 0, 0, 0);
    step(E, 0, 0, 0, 0, 0, 1);
    mem_addr = 32'h100;
    mem_wdata = 32'hDEADBEEF;
    mem_byteenable = 4'b0011;
    step(F, 0, 0, 0, 0, 0, 0);
    step(E, 1, 1, 1, 0, 1, 0);
    step(E, 1, 1, 1, 0, 1, 0);
    step(E, 0, 1, 1, 0, 0, 1);
    mem_addr = 32'h200;
    mem_byteenable = 4'b1100;
    step(F, 0, 0, 0, 0, 0, 0);
    step(E, 0, 1, 0, 0, 0, 1);
    step(F, 0, 0, 0, 0, 0, 0);
    step(E, 1, 1, 0, 0, 1, 0);
    step(E, 0, 1, 0, 0, 0, 1);
    mem_addr = 32'h300;
    mem_wdata = 32'h12345678;
    mem_byteenable = 4'hF;
    step(F, 0, 0, 0, 0, 0, 0);
    step(E, 1, 1, 1, 1, 1, 0);
    step(E, 0, 1, 1, 1, 0, 1);
    repeat (100) step(H, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    reset_n = 0;
    #1;
    chk("halt rst count", instr_count, 0);
    cnt_exp = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    step(I, 1, 0, 0, 0, 0, 0);
`ifdef FETCH_SEQ_TIMEOUT_EN
    repeat (8) step(F, 1, 0, 0, 0, 0, 0);
    repeat (3) step(X, 1, 0, 0, 0, 0, 0);
`else
    repeat (1000) step(F, 1, 0, 0, 0, 0, 0);
`endif
    reset_n = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    cnt_exp = 0;
    step(I, 0, 0, 0, 0, 0, 0);
    step(F, 0, 0, 0, 0, 0, 0);
    step(E, 0, 0, 0, 0, 0, 1);
    step(F, 0, 0, 0, 0, 0, 0);
    waitrequest = 1;
    mem_req = 1;
    mem_we = 0;
    #1;
    chk("pend read", 32'(read), 1);
    chk("pend stall", 32'(stall), 1);
    chk("pend count", instr_count, 1);
    reset_n = 0;
    #1;
    chk("mid rst read", 32'(read), 0);
    chk("mid rst stall", 32'(stall), 0);
    chk("mid rst count", instr_count, 0);
    chk("mid rst state", 32'(state), 0);
    @(posedge clk);
    #1;
    reset_n = 1;
    cnt_exp = 0;
    step(I, 0, 0, 0, 0, 0, 0);
    step(F, 0, 0, 0, 0, 0, 0);
    step(E, 0, 0, 0, 0, 0, 1);
    step(F, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Top-level bus sequencer for the bus-based MIPS CPU. It owns the single Avalon-style memory port and alternates instruction FETCH and EXEC phases. It drives the instruction register's `state` and `stall` inputs, arbitrates the port between the fetch path and the datapath's load/store request, and gates PC advance. It also tracks halt and retired-instruction count and, optionally, bus timeouts.

## Interface
- `TIMEOUT_CYCLES`, 1024: consecutive `waitrequest` cycles tolerated before fault (used only with the timeout feature compiled in).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pc` in 32: current program counter.
- `mem_req` in 1: datapath requests a data access during EXEC.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in 32: data address.
- `mem_byteenable` in 4: data byte lanes.
- `mem_wdata` in 32: store data.
- `halt_req` in 1: the executing instruction ends the program (jump to 0).
- `waitrequest` in 1: bus not ready.
- `address` out 32: bus address.
- `read` out 1: bus read strobe.
- `write` out 1: bus write strobe.
- `byteenable` out 4: bus byte lanes.
- `writedata` out 32: bus write data.
- `state` out 1: 1 in EXEC; feeds the instruction register.
- `stall` out 1: EXEC held by a pending data access.
- `pc_en` out 1: one-cycle strobe to advance PC.
- `active` out 1: CPU running.
- `bus_error` out 1: sticky timeout fault.
- `instr_count` out 32: retired instructions.

## Operation
- States: IDLE, FETCH, EXEC, HALT, FAULT. Registered state; bus outputs are combinational from state and inputs.
- IDLE: all strobes 0. Always goes to FETCH on the next edge. `active` becomes 1 on entry to FETCH.
- FETCH:
  - `read`=1, `address`=`pc`, `byteenable`=4'hF.
  - Hold while `waitrequest`=1.
  - On `waitrequest`=0, go to EXEC.
- EXEC: `state`=1.
  - If `mem_req`=0: instruction retires this cycle.
  - If `mem_req`=1: drive `address`=`mem_addr`, `byteenable`=`mem_byteenable`, and `writedata`=`mem_wdata`. Assert `write`=`mem_we` and `read`=!`mem_we`.
  - `stall`=`waitrequest` while the access is pending. Remain in EXEC. The datapath holds its request stable.
  - Retires when the access completes (`waitrequest`=0).
- Retire cycle:
  - `pc_en`=1 and `instr_count`+1.
  - Next state is HALT if `halt_req`=1, else FETCH.
- HALT: sticky until reset. `active`=0; all strobes 0; `pc_en`=0.
- FAULT: see Configuration. Sticky until reset.
- `instr_count` wraps from 0xFFFFFFFF to 0.
- `read` and `write` are never asserted together.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE.
  - `read`=`write`=`state`=`stall`=`pc_en`=`active`=`bus_error`=0.
  - `address`=0, `byteenable`=0, `writedata`=0, `instr_count`=0.
- Reset mid-access drops `read`/`write` without waiting for `waitrequest`.
- Zero-wait instruction without data access: 2 cycles (FETCH, EXEC).
- Zero-wait load/store: 2 cycles.
- Each `waitrequest` cycle adds exactly one cycle.
- `stall` is high only during EXEC cycles with `mem_req`=1 and `waitrequest`=1.
  - It is low on the first EXEC cycle when the access completes immediately, so the instruction register captures `read_data` on the first EXEC cycle.
- `pc_en` is high for exactly one cycle per retired instruction, on the EXEC exit edge.
- `halt_req` is sampled only on the retire cycle.
  - A halting load/store still completes its bus access before HALT.

## Configuration
- Macro: `FETCH_SEQ_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter counts consecutive cycles with a strobe asserted and `waitrequest`=1 (FETCH or EXEC). It clears on any cycle without that condition.
  - When the count reaches `TIMEOUT_CYCLES`, the next state is FAULT: strobes 0, `active`=0, `bus_error`=1.
- Undefined:
  - No counter. Waits indefinitely.
  - `bus_error` tied 0; FAULT unreachable.

## Test plan
- Release reset, `waitrequest`=0, `mem_req`=0, `pc`=0xBFC00000:
  - `read` with `address`=0xBFC00000 on cycle 2.
  - `state`=1 on cycle 3.
  - `pc_en` pulses every 2 cycles; `instr_count`=4 after 8 cycles.
- Fetch with `waitrequest` high 3 cycles: FETCH lasts 4 cycles, then EXEC; `stall` never asserted.
- EXEC store, `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF, `mem_byteenable`=4'b0011, `waitrequest` high 2 cycles:
  - `write`=1 for 3 cycles with those values; `read`=0.
  - `stall`=1 for 2 cycles, then `pc_en`.
- `halt_req`=1 on a retire: `active`=0 on the next cycle; no further `read`; state stays HALT for 100 cycles.
- With `FETCH_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `waitrequest` stuck high in FETCH: `bus_error`=1 and `read`=0 after 8 wait cycles. Without the macro: `read` still 1 after 1000 cycles.
- Drive `reset_n` low during a pending load with `waitrequest`=1: `read`, `stall`, and `instr_count` clear immediately; after release, fetch restarts from IDLE.
